new_cache_control: RTL

Sequencing controller for the direct-mapped, write-back L1 cache built around the 8-set × 256-bit byte-enabled line data array. It accepts 32-bit CPU load/store requests, owns the tag/valid/dirty metadata, and drives the data array's read index, write index, byte write-enables and write data. On a miss it runs writeback and fill bursts over a 256-bit physical-memory handshake. It sits between the CPU memory port and the cacheline adaptor.

---
 rtl/cache_types_pkg.sv | 18 +
 rtl/new_meta_array.sv | 49 ++++
 rtl/new_cache_control.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared widths and controller state encoding for the direct-mapped,
// write-back L1 cache controller.
package cache_types_pkg;

  localparam int s_offset = 5;
  localparam int s_index  = 3;
  localparam int s_tag    = 32 - s_offset - s_index;
  localparam int s_mask   = 2 ** s_offset;
  localparam int s_line   = 8 * s_mask;
  localparam int num_sets = 2 ** s_index;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } ctrl_state_t;

endpackage

// File: rtl/new_meta_array.sv
// Per-set tag, valid and dirty storage with combinational read and
// independently strobed synchronous writes.
module new_meta_array
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [s_index-1:0] index,
  input  logic               load_tag,
  input  logic               load_valid,
  input  logic               load_dirty,
  input  logic [s_tag-1:0]   tag_in,
  input  logic               valid_in,
  input  logic               dirty_in,
  output logic [s_tag-1:0]   tag_out,
  output logic               valid_out,
  output logic               dirty_out
);

  logic [num_sets-1:0][s_tag-1:0] tag_q, tag_d;
  logic [num_sets-1:0]            valid_q, valid_d;
  logic [num_sets-1:0]            dirty_q, dirty_d;

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (load_tag)   tag_d[index]   = tag_in;
    if (load_valid) valid_d[index] = valid_in;
    if (load_dirty) dirty_d[index] = dirty_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign tag_out   = tag_q[index];
  assign valid_out = valid_q[index];
  assign dirty_out = dirty_q[index];

endmodule

// File: rtl/new_cache_control.sv
// Sequencing controller for the direct-mapped write-back L1: hit handling,
// dirty writeback and line fill over the 256-bit memory handshake.
module new_cache_control
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_address,
  input  logic [3:0]         mem_byte_enable,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_resp,
  output logic [s_index-1:0] da_rindex,
  output logic [s_index-1:0] da_windex,
  output logic [s_mask-1:0]  da_write_en,
  output logic [s_line-1:0]  da_datain,
  input  logic [s_line-1:0]  da_dataout,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [s_line-1:0]  pmem_wdata,
  input  logic [s_line-1:0]  pmem_rdata,
  input  logic               pmem_resp
);

  ctrl_state_t state_q, state_d;

  logic [s_tag-1:0]   req_tag;
  logic [s_index-1:0] req_index;
  logic [2:0]         req_word;
  logic               req_valid;
  logic               hit;
  logic               unused_addr_bits;

  logic               load_tag, load_valid, load_dirty;
  logic               valid_in, dirty_in;
  logic [s_tag-1:0]   tag_out;
  logic               valid_out, dirty_out;

  assign req_tag          = mem_address[31:s_offset+s_index];
  assign req_index        = mem_address[s_offset+s_index-1:s_offset];
  assign req_word         = mem_address[s_offset-1:2];
  assign unused_addr_bits = ^mem_address[1:0];
  assign req_valid        = mem_read | mem_write;
  assign hit              = valid_out && (tag_out == req_tag);

  assign da_rindex = req_index;
  assign da_windex = req_index;

  new_meta_array u_meta (
    .clk        (clk),
    .rst        (rst),
    .index      (req_index),
    .load_tag   (load_tag),
    .load_valid (load_valid),
    .load_dirty (load_dirty),
    .tag_in     (req_tag),
    .valid_in   (valid_in),
    .dirty_in   (dirty_in),
    .tag_out    (tag_out),
    .valid_out  (valid_out),
    .dirty_out  (dirty_out)
  );

  // Everything is gated by rst so a reset coincident with pmem_resp
  // abandons the burst without touching metadata or the data array.
  always_comb begin
    state_d      = state_q;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    da_write_en  = '0;
    da_datain    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    load_tag     = 1'b0;
    load_valid   = 1'b0;
    load_dirty   = 1'b0;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (hit) begin
              mem_resp = 1'b1;
              if (mem_read) begin
                mem_rdata = da_dataout[{req_word, 5'b0} +: 32];
              end else begin
                da_write_en = s_mask'(mem_byte_enable) << {req_word, 2'b00};
                da_datain   = {8{mem_wdata}};
                load_dirty  = 1'b1;
                dirty_in    = 1'b1;
              end
            end else begin
              state_d = (valid_out && dirty_out) ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          pmem_address = {tag_out, req_index, {s_offset{1'b0}}};
          pmem_wdata   = da_dataout;
          if (pmem_resp) begin
            load_dirty = 1'b1;
            state_d    = FILL;
          end
        end
        FILL: begin
          pmem_read    = 1'b1;
          pmem_address = {req_tag, req_index, {s_offset{1'b0}}};
          da_datain    = pmem_rdata;
          if (pmem_resp) begin
            da_write_en = '1;
            load_tag    = 1'b1;
            load_valid  = 1'b1;
            valid_in    = 1'b1;
            load_dirty  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule
